// File: rtl/cnt_cfg_pkg.sv
// ---------------------------------------------------------------------------
// cnt_cfg_pkg
// Shared definitions for the counter-table configuration-access engine:
// default counter ID / record widths, the default port-A read latency,
// the config op-code enumeration and a helper for the channel-index width.
// No ports (package).
// ---------------------------------------------------------------------------
package cnt_cfg_pkg;

    localparam int CNT_ID_W   = 14;
    localparam int CNT_DATA_W = 512;
    localparam int CNT_RD_LAT = 2;

    // Op codes carried on req_op; the unused code 2'b11 is handled as a read.
    typedef enum logic [1:0] {
        CFG_RD     = 2'b00,
        CFG_WR     = 2'b01,
        CFG_RD_CLR = 2'b10
    } cfg_op_e;

    // Width of a channel index; a single channel still gets one bit so that
    // rsp_ch never collapses to a zero-width vector.
    function automatic int ch_idx_w(input int n_ch);
        return (n_ch > 1) ? $clog2(n_ch) : 1;
    endfunction

endpackage

// File: rtl/cnt_table_cfg_arb_if.sv
// ---------------------------------------------------------------------------
// cnt_table_cfg_arb_if
// Bundle of the host-side config request channels and the read-response
// channel of the counter-table config engine.
//   req_vld   [N_CH]         per-channel request valid      (master -> slave)
//   req_rdy   [N_CH]         per-channel accept, one-hot/0   (slave -> master)
//   req_op    [2*N_CH]       per-channel op code             (master -> slave)
//   req_id    [ID_W*N_CH]    per-channel counter ID          (master -> slave)
//   req_wdata [DATA_W*N_CH]  per-channel write data          (master -> slave)
//   rsp_vld                  read response valid             (slave -> master)
//   rsp_rdy                  read response accept            (master -> slave)
//   rsp_ch    [CH_W]         channel that issued the read    (slave -> master)
//   rsp_data  [DATA_W]       counter record read             (slave -> master)
// ---------------------------------------------------------------------------
interface cnt_table_cfg_arb_if
    import cnt_cfg_pkg::*;
#(
    parameter int N_CH   = 2,
    parameter int ID_W   = CNT_ID_W,
    parameter int DATA_W = CNT_DATA_W,
    parameter int CH_W   = ch_idx_w(N_CH)
);

    logic [N_CH-1:0]        req_vld;
    logic [N_CH-1:0]        req_rdy;
    logic [2*N_CH-1:0]      req_op;
    logic [ID_W*N_CH-1:0]   req_id;
    logic [DATA_W*N_CH-1:0] req_wdata;

    logic                   rsp_vld;
    logic                   rsp_rdy;
    logic [CH_W-1:0]        rsp_ch;
    logic [DATA_W-1:0]      rsp_data;

    // Host side: issues requests, consumes responses.
    modport master (
        output req_vld, req_op, req_id, req_wdata, rsp_rdy,
        input  req_rdy, rsp_vld, rsp_ch, rsp_data
    );

    // Engine side: accepts requests, produces responses.
    modport slave (
        input  req_vld, req_op, req_id, req_wdata, rsp_rdy,
        output req_rdy, rsp_vld, rsp_ch, rsp_data
    );

endinterface

// File: rtl/cnt_rsp_fifo.sv
// ---------------------------------------------------------------------------
// cnt_rsp_fifo
// Synchronous first-word-fall-through FIFO holding read responses
// ({channel, record}) until the host accepts them.
//   asclk      in   clock, rising edge
//   areset     in   synchronous active-high reset (empties the FIFO)
//   push       in   write push_data this cycle
//   push_data  in   [WIDTH] entry to store
//   pop        in   drop the head entry this cycle (ignored when empty)
//   head_data  out  [WIDTH] current head entry, zero while empty
//   empty      out  no entry stored
// The producer never pushes into a full FIFO (read credits guarantee it),
// so no full flag is exported.
// ---------------------------------------------------------------------------
module cnt_rsp_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             asclk,
    input  logic             areset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head_data,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;

    // Pointers carry one extra wrap bit so equal pointers mean empty and
    // differing wrap bits with equal index bits would mean full.
    always_ff @(posedge asclk) begin
        if (areset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop && !empty) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

    // Storage needs no reset; stale entries are never visible because the
    // head is masked while the FIFO is empty.
    always_ff @(posedge asclk) begin
        if (push) begin
            mem[wr_ptr[AW-1:0]] <= push_data;
        end
    end

    assign empty     = (wr_ptr == rd_ptr);
    assign head_data = empty ? '0 : mem[rd_ptr[AW-1:0]];

endmodule

// File: rtl/cnt_table_cfg_arb.sv
// ---------------------------------------------------------------------------
// cnt_table_cfg_arb
// Configuration-access engine for port A of the counter-table BRAM.
// N_CH host channels are round-robin arbitrated onto the single port; reads
// (and read-and-clear) are tagged through an RD_LAT-deep pipeline and their
// results collected in a response FIFO, guarded by read credits so the FIFO
// can never overflow while the host applies backpressure.
//   asclk      in   clock, rising edge
//   areset     in   synchronous active-high reset
//   cfg        slave modport of cnt_table_cfg_arb_if (requests + responses)
//   bram_we    out  port-A write enable (registered)
//   bram_addr  out  [ID_W] port-A address (registered)
//   bram_din   out  [DATA_W] port-A write data (registered)
//   bram_dout  in   [DATA_W] port-A read data, RD_LAT cycles after address
// ---------------------------------------------------------------------------
module cnt_table_cfg_arb
    import cnt_cfg_pkg::*;
#(
    parameter int N_CH      = 2,
    parameter int ID_W      = CNT_ID_W,
    parameter int DATA_W    = CNT_DATA_W,
    parameter int RD_LAT    = CNT_RD_LAT,
    parameter int RSP_DEPTH = 4
) (
    input  logic                asclk,
    input  logic                areset,
    cnt_table_cfg_arb_if.slave  cfg,
    output logic                bram_we,
    output logic [ID_W-1:0]     bram_addr,
    output logic [DATA_W-1:0]   bram_din,
    input  logic [DATA_W-1:0]   bram_dout
);

    localparam int CH_W  = ch_idx_w(N_CH);
    localparam int CRD_W = $clog2(RSP_DEPTH + 1);

    // The port is either free, or spending one cycle writing zero back to
    // the ID that a read-and-clear just read.
    typedef enum logic {
        PORT_IDLE,
        PORT_CLR_WB
    } port_state_e;

    port_state_e        port_state_q;
    port_state_e        port_state_d;

    logic [CH_W-1:0]    rr_ptr;
    logic [CRD_W-1:0]   credits;

    logic [N_CH-1:0]    eligible;
    logic               gnt_any;
    logic [CH_W-1:0]    gnt_ch;
    logic [1:0]         gnt_op;
    logic [ID_W-1:0]    gnt_id;
    logic [DATA_W-1:0]  gnt_wdata;
    logic               gnt_is_rd;

    logic               issue_vld;
    logic [CH_W-1:0]    issue_ch;
    logic [RD_LAT-1:0]  tag_vld;
    logic [CH_W-1:0]    tag_ch [RD_LAT];

    logic               fifo_empty;
    logic [DATA_W+CH_W-1:0] fifo_head;
    logic               rsp_pop;

    // A write never produces a response, so it is always eligible; anything
    // that reads needs a free slot in the response FIFO, i.e. a credit.
    always_comb begin
        eligible = '0;
        for (int i = 0; i < N_CH; i++) begin
            if (cfg.req_vld[i]) begin
                if (cfg.req_op[2*i +: 2] == CFG_WR) begin
                    eligible[i] = 1'b1;
                end else begin
                    eligible[i] = (credits != '0);
                end
            end
        end
    end

    // Round-robin pick: scan from the pointer and take the first eligible
    // channel. No grant while in reset or during a clear write-back cycle.
    always_comb begin : arb_pick
        int idx;
        idx     = 0;
        gnt_any = 1'b0;
        gnt_ch  = '0;
        for (int i = 0; i < N_CH; i++) begin
            idx = (int'(rr_ptr) + i) % N_CH;
            if (!gnt_any && eligible[CH_W'(idx)]) begin
                gnt_any = 1'b1;
                gnt_ch  = CH_W'(idx);
            end
        end
        if (areset || (port_state_q != PORT_IDLE)) begin
            gnt_any = 1'b0;
            gnt_ch  = '0;
        end
    end

    // Fields of the granted channel, plus the one-hot accept back to it.
    always_comb begin
        gnt_op      = cfg.req_op[2*int'(gnt_ch) +: 2];
        gnt_id      = cfg.req_id[ID_W*int'(gnt_ch) +: ID_W];
        gnt_wdata   = cfg.req_wdata[DATA_W*int'(gnt_ch) +: DATA_W];
        gnt_is_rd   = gnt_any && (gnt_op != CFG_WR);
        cfg.req_rdy = '0;
        if (gnt_any) begin
            cfg.req_rdy[gnt_ch] = 1'b1;
        end
    end

    // Port state register.
    always_ff @(posedge asclk) begin
        if (areset) begin
            port_state_q <= PORT_IDLE;
        end else begin
            port_state_q <= port_state_d;
        end
    end

    // A read-and-clear grant reserves the following cycle for the zero
    // write; that cycle always returns the port to idle.
    always_comb begin
        port_state_d = PORT_IDLE;
        if ((port_state_q == PORT_IDLE) && gnt_any && (gnt_op == CFG_RD_CLR)) begin
            port_state_d = PORT_CLR_WB;
        end
    end

    // Port-A drive and the issue-stage tag. The address is only replaced on
    // a grant so the clear write-back reuses the address of its read; write
    // data is only replaced by an actual write or the clear's zero.
    always_ff @(posedge asclk) begin
        if (areset) begin
            rr_ptr    <= '0;
            bram_we   <= 1'b0;
            bram_addr <= '0;
            bram_din  <= '0;
            issue_vld <= 1'b0;
            issue_ch  <= '0;
        end else begin
            if (gnt_any) begin
                rr_ptr <= (gnt_ch == CH_W'(N_CH - 1)) ? '0 : gnt_ch + 1'b1;
            end
            if (port_state_q == PORT_CLR_WB) begin
                bram_we  <= 1'b1;
                bram_din <= '0;
            end else if (gnt_any) begin
                bram_addr <= gnt_id;
                bram_we   <= (gnt_op == CFG_WR);
                if (gnt_op == CFG_WR) begin
                    bram_din <= gnt_wdata;
                end
            end else begin
                bram_we <= 1'b0;
            end
            issue_vld <= gnt_is_rd;
            issue_ch  <= gnt_ch;
        end
    end

    // The tag follows the address through the BRAM latency so that the last
    // stage lines up with the matching bram_dout.
    always_ff @(posedge asclk) begin
        if (areset) begin
            tag_vld <= '0;
            for (int k = 0; k < RD_LAT; k++) begin
                tag_ch[k] <= '0;
            end
        end else begin
            tag_vld[0] <= issue_vld;
            tag_ch[0]  <= issue_ch;
            for (int k = 1; k < RD_LAT; k++) begin
                tag_vld[k] <= tag_vld[k-1];
                tag_ch[k]  <= tag_ch[k-1];
            end
        end
    end

    assign rsp_pop = !fifo_empty && cfg.rsp_rdy;

    // One credit per free FIFO slot: taken when a read is granted, returned
    // when the host pops a response. Both in one cycle cancel out.
    always_ff @(posedge asclk) begin
        if (areset) begin
            credits <= CRD_W'(RSP_DEPTH);
        end else begin
            case ({gnt_is_rd, rsp_pop})
                2'b10:   credits <= credits - 1'b1;
                2'b01:   credits <= credits + 1'b1;
                default: credits <= credits;
            endcase
        end
    end

    cnt_rsp_fifo #(
        .WIDTH (DATA_W + CH_W),
        .DEPTH (RSP_DEPTH)
    ) u_rsp_fifo (
        .asclk     (asclk),
        .areset    (areset),
        .push      (tag_vld[RD_LAT-1]),
        .push_data ({tag_ch[RD_LAT-1], bram_dout}),
        .pop       (rsp_pop),
        .head_data (fifo_head),
        .empty     (fifo_empty)
    );

    assign cfg.rsp_vld  = !fifo_empty;
    assign cfg.rsp_ch   = fifo_head[DATA_W +: CH_W];
    assign cfg.rsp_data = fifo_head[DATA_W-1:0];

endmodule

// File: tb/tb_cnt_table_cfg_arb.sv
// ---------------------------------------------------------------------------
// tb_cnt_table_cfg_arb
// Self-checking bench for cnt_table_cfg_arb. A behavioural model tracks the
// counter table in grant order, predicts which channel is accepted each
// cycle, and keeps a queue of expected responses with their earliest cycle.
// A separate BRAM model is driven only by the DUT's port-A outputs.
// ---------------------------------------------------------------------------
module tb_cnt_table_cfg_arb;
    import cnt_cfg_pkg::*;

    localparam int N_CH      = 2;
    localparam int ID_W      = 14;
    localparam int DATA_W    = 512;
    localparam int RD_LAT    = 2;
    localparam int RSP_DEPTH = 4;
    localparam int CH_W      = 1;

    typedef struct {
        int                ch;
        logic [DATA_W-1:0] data;
        longint            due;
    } rsp_t;

    logic              asclk;
    logic              areset;
    logic              bram_we;
    logic [ID_W-1:0]   bram_addr;
    logic [DATA_W-1:0] bram_din;
    logic [DATA_W-1:0] bram_dout;

    int checks;
    int errors;

    // Bench-side BRAM: storage plus the read-latency pipe.
    logic [DATA_W-1:0] tb_mem [64];
    logic [DATA_W-1:0] rd_pipe [RD_LAT];

    // Reference model state.
    logic [DATA_W-1:0] model_mem [64];
    rsp_t              exp_q [$];
    int                m_ptr;
    int                m_credits;
    bit                m_busy;
    bit                m_live;
    logic              m_we;
    logic [ID_W-1:0]   m_addr;
    logic [DATA_W-1:0] m_din;
    longint            cyc;
    logic              rst_at_edge;
    int                hs_cnt [N_CH];

    cnt_table_cfg_arb_if #(
        .N_CH   (N_CH),
        .ID_W   (ID_W),
        .DATA_W (DATA_W),
        .CH_W   (CH_W)
    ) cfg_bus ();

    cnt_table_cfg_arb #(
        .N_CH      (N_CH),
        .ID_W      (ID_W),
        .DATA_W    (DATA_W),
        .RD_LAT    (RD_LAT),
        .RSP_DEPTH (RSP_DEPTH)
    ) dut (
        .asclk     (asclk),
        .areset    (areset),
        .cfg       (cfg_bus),
        .bram_we   (bram_we),
        .bram_addr (bram_addr),
        .bram_din  (bram_din),
        .bram_dout (bram_dout)
    );

    initial asclk = 1'b0;
    always #5 asclk = ~asclk;

    initial begin
        for (int i = 0; i < 64; i++) begin
            tb_mem[i]    = '0;
            model_mem[i] = '0;
        end
    end

    // BRAM port A: read-first, RD_LAT cycles from address to dout.
    always @(posedge asclk) begin
        rd_pipe[0] <= tb_mem[bram_addr[5:0]];
        for (int k = 1; k < RD_LAT; k++) begin
            rd_pipe[k] <= rd_pipe[k-1];
        end
        if (bram_we === 1'b1) begin
            tb_mem[bram_addr[5:0]] <= bram_din;
        end
    end
    assign bram_dout = rd_pipe[RD_LAT-1];

    always @(posedge asclk) begin
        cyc         <= cyc + 1;
        rst_at_edge <= areset;
    end

    task automatic checkOutput(input string tag, input logic [DATA_W-1:0] observed,
                               input logic [DATA_W-1:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, observed, expected);
        end
    endtask

    function automatic logic [DATA_W-1:0] randData();
        logic [DATA_W-1:0] v;
        for (int w = 0; w < DATA_W / 32; w++) begin
            v[w*32 +: 32] = $urandom;
        end
        return v;
    endfunction

    task automatic modelReset();
        m_ptr     = 0;
        m_credits = RSP_DEPTH;
        m_busy    = 1'b0;
        m_we      = 1'b0;
        m_addr    = '0;
        m_din     = '0;
        exp_q.delete();
    endtask

    // One cycle of the reference: check the port, the accept vector and the
    // response head, then apply this cycle's grant to the table model.
    task automatic modelStep();
        int                g;
        int                idx;
        logic [1:0]        op;
        logic [ID_W-1:0]   id;
        logic [DATA_W-1:0] wd;
        logic [N_CH-1:0]   exp_rdy;
        bit                exp_v;
        rsp_t              r;

        checkOutput("bram_we", DATA_W'(bram_we), DATA_W'(m_we));
        checkOutput("bram_addr", DATA_W'(bram_addr), DATA_W'(m_addr));
        checkOutput("bram_din", bram_din, m_din);

        g = -1;
        if (!m_busy) begin
            for (int i = 0; i < N_CH; i++) begin
                idx = (m_ptr + i) % N_CH;
                op  = cfg_bus.req_op[2*idx +: 2];
                if (g < 0 && cfg_bus.req_vld[idx] && (op == CFG_WR || m_credits > 0)) begin
                    g = idx;
                end
            end
        end
        exp_rdy = '0;
        if (g >= 0) exp_rdy[g] = 1'b1;
        checkOutput("req_rdy", DATA_W'(cfg_bus.req_rdy), DATA_W'(exp_rdy));
        for (int c = 0; c < N_CH; c++) begin
            if (cfg_bus.req_vld[c] && cfg_bus.req_rdy[c]) hs_cnt[c]++;
        end

        exp_v = (exp_q.size() > 0) && (exp_q[0].due <= cyc);
        checkOutput("rsp_vld", DATA_W'(cfg_bus.rsp_vld), DATA_W'(exp_v));
        if (exp_v && cfg_bus.rsp_vld) begin
            checkOutput("rsp_ch", DATA_W'(cfg_bus.rsp_ch), DATA_W'(exp_q[0].ch));
            checkOutput("rsp_data", cfg_bus.rsp_data, exp_q[0].data);
            if (cfg_bus.rsp_rdy) begin
                void'(exp_q.pop_front());
                m_credits++;
            end
        end

        if (m_busy) begin
            m_we   = 1'b1;
            m_din  = '0;
            m_busy = 1'b0;
        end else if (g >= 0) begin
            op     = cfg_bus.req_op[2*g +: 2];
            id     = cfg_bus.req_id[g*ID_W +: ID_W];
            wd     = cfg_bus.req_wdata[g*DATA_W +: DATA_W];
            m_addr = id;
            if (op == CFG_WR) begin
                m_we = 1'b1;
                m_din = wd;
                model_mem[id[5:0]] = wd;
            end else begin
                m_we   = 1'b0;
                r.ch   = g;
                r.data = model_mem[id[5:0]];
                r.due  = cyc + 2 + RD_LAT;
                exp_q.push_back(r);
                m_credits--;
                if (op == CFG_RD_CLR) begin
                    model_mem[id[5:0]] = '0;
                    m_busy = 1'b1;
                end
            end
            m_ptr = (g + 1) % N_CH;
        end else begin
            m_we = 1'b0;
        end
    endtask

    // Monitor on the falling edge, away from the active clock edge.
    always @(negedge asclk) begin
        if (rst_at_edge === 1'b1) begin
            modelReset();
            m_live = 1'b1;
            checkOutput("rst_bram_we", DATA_W'(bram_we), '0);
            checkOutput("rst_bram_addr", DATA_W'(bram_addr), '0);
            checkOutput("rst_bram_din", bram_din, '0);
            checkOutput("rst_rsp_vld", DATA_W'(cfg_bus.rsp_vld), '0);
            checkOutput("rst_rsp_ch", DATA_W'(cfg_bus.rsp_ch), '0);
            checkOutput("rst_rsp_data", cfg_bus.rsp_data, '0);
        end
        if (m_live) begin
            if (areset) begin
                checkOutput("rst_req_rdy", DATA_W'(cfg_bus.req_rdy), '0);
            end else begin
                modelStep();
            end
        end
    end

    // Present one request on a channel and hold it until it is accepted.
    task automatic applyStimulus(input int ch, input logic [1:0] op, input int id,
                                 input logic [DATA_W-1:0] d);
        int k;
        cfg_bus.req_vld[ch]                    = 1'b1;
        cfg_bus.req_op[2*ch +: 2]              = op;
        cfg_bus.req_id[ch*ID_W +: ID_W]        = ID_W'(id);
        cfg_bus.req_wdata[ch*DATA_W +: DATA_W] = d;
        for (k = 0; k < 100; k++) begin
            @(negedge asclk);
            if (cfg_bus.req_rdy[ch]) break;
        end
        @(posedge asclk);
        #1;
        cfg_bus.req_vld[ch] = 1'b0;
        if (k == 100) checkOutput("req_accept_timeout", DATA_W'(0), DATA_W'(1));
    endtask

    task automatic waitDrain(input int budget);
        for (int k = 0; k < budget; k++) begin
            if (exp_q.size() == 0) break;
            @(posedge asclk);
            #1;
        end
        checkOutput("drain", DATA_W'(exp_q.size()), '0);
    endtask

    task automatic idleCycles(input int n);
        repeat (n) @(posedge asclk);
        #1;
    endtask

    initial begin
        int base0;
        int base1;
        int k;
        checks = 0;
        errors = 0;
        cyc    = 0;
        m_live = 1'b0;
        for (int c = 0; c < N_CH; c++) hs_cnt[c] = 0;
        modelReset();
        cfg_bus.req_vld   = '0;
        cfg_bus.req_op    = '0;
        cfg_bus.req_id    = '0;
        cfg_bus.req_wdata = '0;
        cfg_bus.rsp_rdy   = 1'b0;
        areset            = 1'b1;
        repeat (3) @(posedge asclk);
        #1;
        areset = 1'b0;

        $display("[TB] write then read of id 5");
        cfg_bus.rsp_rdy = 1'b1;
        applyStimulus(0, CFG_WR, 5, DATA_W'(32'hA5A5));
        applyStimulus(1, CFG_RD, 5, '0);
        waitDrain(50);

        $display("[TB] alternating reads on both channels");
        applyStimulus(0, CFG_WR, 1, DATA_W'(32'h1111_0001));
        applyStimulus(1, CFG_WR, 2, DATA_W'(32'h2222_0002));
        cfg_bus.req_op    = {CFG_RD, CFG_RD};
        cfg_bus.req_id    = {ID_W'(2), ID_W'(1)};
        cfg_bus.req_vld   = '1;
        idleCycles(12);
        cfg_bus.req_vld   = '0;
        waitDrain(50);

        $display("[TB] credit exhaustion with stalled responses");
        cfg_bus.rsp_rdy = 1'b0;
        base0 = hs_cnt[0];
        base1 = hs_cnt[1];
        cfg_bus.req_op[1:0]   = CFG_RD;
        cfg_bus.req_id[ID_W-1:0] = ID_W'(1);
        cfg_bus.req_vld[0]    = 1'b1;
        idleCycles(8);
        checkOutput("stall_reads_accepted", DATA_W'(hs_cnt[0] - base0), DATA_W'(4));
        applyStimulus(1, CFG_WR, 3, DATA_W'(32'h3333_0003));
        checkOutput("stall_write_accepted", DATA_W'(hs_cnt[1] - base1), DATA_W'(1));
        cfg_bus.rsp_rdy = 1'b1;
        for (k = 0; k < 100; k++) begin
            @(posedge asclk);
            #1;
            if (hs_cnt[0] - base0 >= 6) break;
        end
        cfg_bus.req_vld[0] = 1'b0;
        checkOutput("stall_reads_total", DATA_W'(hs_cnt[0] - base0), DATA_W'(6));
        waitDrain(50);

        $display("[TB] read-and-clear of id 7");
        applyStimulus(0, CFG_WR, 7, DATA_W'(32'h1234));
        applyStimulus(0, CFG_RD_CLR, 7, '0);
        applyStimulus(1, CFG_RD, 7, '0);
        waitDrain(50);

        $display("[TB] read right after write of id 9");
        applyStimulus(0, CFG_WR, 9, randData());
        applyStimulus(1, CFG_RD, 9, '0);
        waitDrain(50);

        $display("[TB] reset with reads in flight");
        cfg_bus.rsp_rdy = 1'b0;
        applyStimulus(0, CFG_RD, 1, '0);
        applyStimulus(1, CFG_RD, 2, '0);
        applyStimulus(0, CFG_RD, 3, '0);
        areset = 1'b1;
        idleCycles(1);
        areset = 1'b0;
        cfg_bus.rsp_rdy = 1'b1;
        idleCycles(12);
        cfg_bus.rsp_rdy = 1'b0;
        base0 = hs_cnt[0];
        cfg_bus.req_op[1:0]      = CFG_RD;
        cfg_bus.req_id[ID_W-1:0] = ID_W'(2);
        cfg_bus.req_vld[0]       = 1'b1;
        idleCycles(8);
        cfg_bus.req_vld[0] = 1'b0;
        checkOutput("post_reset_credits", DATA_W'(hs_cnt[0] - base0), DATA_W'(RSP_DEPTH));
        cfg_bus.rsp_rdy = 1'b1;
        waitDrain(50);

        $display("[TB] randomized traffic");
        for (int n = 0; n < 3000; n++) begin
            for (int ch = 0; ch < N_CH; ch++) begin
                cfg_bus.req_vld[ch]                    = ($urandom_range(0, 99) < 60);
                cfg_bus.req_op[2*ch +: 2]              = 2'($urandom_range(0, 3));
                cfg_bus.req_id[ch*ID_W +: ID_W]        = ID_W'($urandom_range(0, 15));
                cfg_bus.req_wdata[ch*DATA_W +: DATA_W] = randData();
            end
            cfg_bus.rsp_rdy = ($urandom_range(0, 99) < 70);
            idleCycles(1);
        end
        cfg_bus.req_vld = '0;
        cfg_bus.rsp_rdy = 1'b1;
        waitDrain(100);
        idleCycles(4);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: got timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule

// File: doc/cnt_table_cfg_arb.md
Name: cnt_table_cfg_arb

Overview:
Parametrised configuration-access engine for the counter-table BRAM port A. It replaces the single fixed read/write config port with N_CH independent request channels under round-robin arbitration, a configurable BRAM read latency, and credit-based read-response buffering with backpressure. It adds a read-and-clear operation. It sits between the host config channels and the counter-table RAM; port B stays with the counter logic.

Parameters:
N_CH, 2, number of config request channels (1..8)
ID_W, 14, counter ID / BRAM address width
DATA_W, 512, counter record width
RD_LAT, 2, BRAM port-A read latency in cycles from address to dout (1..4)
RSP_DEPTH, 4, response FIFO depth and number of read credits (power of 2, >=2)

Ports:
asclk  in  1  clock, all logic on rising edge
areset  in  1  reset, synchronous, active-high
req_vld  in  N_CH  per-channel request valid
req_rdy  out  N_CH  per-channel request accept (one-hot or zero)
req_op  in  2*N_CH  per-channel op: 00 read, 01 write, 10 read-clear, 11 treated as read
req_id  in  ID_W*N_CH  per-channel counter ID
req_wdata  in  DATA_W*N_CH  per-channel write data
rsp_vld  out  1  read response valid
rsp_rdy  in  1  read response accept
rsp_ch  out  max(1,clog2(N_CH))  channel that issued the read
rsp_data  out  DATA_W  counter record read
bram_we  out  1  port-A write enable (registered)
bram_addr  out  ID_W  port-A address (registered)
bram_din  out  DATA_W  port-A write data (registered)
bram_dout  in  DATA_W  port-A read data, valid RD_LAT cycles after its address cycle

Behaviour:
- Reset: req_rdy=0, rsp_vld=0, bram_we=0, bram_addr=0, bram_din=0, rsp_ch=0, rsp_data=0. RR pointer=0, credits=RSP_DEPTH, read-tag pipeline cleared, FIFO emptied, pending clear dropped.
- Reset mid-operation: in-flight reads are discarded. No response appears after reset deasserts unless a new read is issued.
- Eligibility: a write is always eligible. A read or read-clear is eligible only when credits>0.
- Arbitration, cycle T: grant the first eligible req_vld at or after the RR pointer. req_rdy[g]=1 combinationally in cycle T and the handshake completes in T. The pointer moves to g+1 mod N_CH. There is at most one grant per cycle.
- Port busy: the cycle after a read-clear grant carries no grant and all req_rdy=0.
- Issue: at T+1, bram_addr=req_id[g]. For a write, bram_we=1 and bram_din=req_wdata[g]; otherwise bram_we=0. When no grant is made, bram_we=0 and addr/din hold.
- Read-clear: at T+1, a read of the ID is issued. At T+2, bram_we=1, same addr, bram_din=0. The read returns the pre-clear value.
- Return: a tag {valid, ch} shifts through an RD_LAT-deep pipeline. At T+1+RD_LAT, bram_dout and ch are written into the FWFT response FIFO (sub-module). rsp_vld is no earlier than T+2+RD_LAT; with defaults, T+4.
- Response handshake: the FIFO pops on rsp_vld&rsp_rdy. rsp_ch and rsp_data are stable while rsp_vld=1 and rsp_rdy=0.
- Credits: decrement on a read grant and increment on a pop. A simultaneous grant and pop leaves credits unchanged. Credits never go below 0 or above RSP_DEPTH, so the FIFO never overflows.
- Ordering: responses return in grant order across all channels. Accesses to the same address are applied in grant order; a read after a write to the same ID returns the new data.
- Writes produce no response.

Decomposition:
- Package cnt_cfg_pkg holds:
  - CNT_ID_W=14 and CNT_DATA_W=512.
  - Default RD_LAT.
  - An enum for the op codes (CFG_RD, CFG_WR, CFG_RD_CLR).
  - A function returning the channel-index width.
- Sub-module cnt_rsp_fifo is a synchronous FWFT FIFO of width DATA_W+CH_W and depth RSP_DEPTH, with synchronous active-high reset.
- Arbiter, tag pipeline and credit counter live in the top level.

Test Plan:
- After reset, write ch0 id 5 data 0xA5A5 -> next cycle bram_we=1, addr=5, din=0xA5A5. Then read ch1 id 5 granted at T -> rsp_vld at T+4, rsp_ch=1, rsp_data=0xA5A5.
- Both channels issue back-to-back reads of ids 1 and 2, rsp_rdy=1 -> grants alternate ch0,ch1,ch0,ch1 and responses arrive in the same order with correct data.
- rsp_rdy=0, ch0 issues 6 reads -> exactly 4 accepted, then req_rdy[0]=0 while a ch1 write is still granted. With rsp_rdy=1, 4 responses drain, then the remaining 2 reads are accepted and returned.
- id 7 holds 0x1234, read-clear at T -> no grant at T+1, bram_we=1 addr=7 din=0 at T+2, response 0x1234. A following read of id 7 returns 0.
- A write to id 9 at T and a read of id 9 at T+1 -> the read returns the new write data.
- 3 reads in flight, areset pulsed for 1 cycle -> rsp_vld=0 and bram_we=0 during reset, no response afterwards, credits=4.
